echo_detect: RTL and testbench
==============================

Name: echo_detect

Overview:
- Upstream stage of the ping timing accumulator.
- Takes the raw comparator bit from the digitizer and the ping-start strobe from the transmitter path.
- Blanks the receiver during and just after transmit, qualifies echo pulses by run length, and emits a clean one-cycle rf_rx_stb per echo with a cycle timestamp relative to ping start.
- Reports window completion so the accumulator can latch begin/end times.

Parameters:
- RUN_MIN, 4: consecutive synchronized high samples required to accept an echo (1..15).
- GAP_MIN, 4: consecutive synchronized low samples required to re-arm after an echo (1..15).
- BLANK, 64: cycles ignored after tx_stb, and after tx_en falls.
- WINDOW, 4096: listen window length in cycles, counted from tx_stb (power of two).
- TW, $clog2(WINDOW): timestamp width.

Ports:
- clk  in  1  system clock (48 MHz xtal).
- rst  in  1  synchronous, active-high reset.
- sig  in  1  raw digitizer output, asynchronous to clk.
- tx_stb  in  1  one-cycle ping start; restarts the window from any state.
- tx_en  in  1  transmitter active level; forces blanking while high.
- rf_rx_stb  out  1  one-cycle pulse per qualified echo.
- first_ts  out  TW  timestamp of first echo in current window.
- last_ts  out  TW  timestamp of most recent echo in current window.
- hit  out  1  at least one echo seen in current window.
- win_done  out  1  one-cycle pulse at end of listen window.
- busy  out  1  high in BLANK or LISTEN.

Behaviour:
- Reset: state IDLE. All outputs 0. Counters 0, armed 0.
- sig passes through a 2-FF synchronizer (sig_s). No combinational path from sig to any output.
- ts_cnt (TW bits):
  - Loads 0 on the edge sampling tx_stb=1.
  - Increments every cycle while busy.
  - Never wraps: the window ends at WINDOW-1.
- FSM:
  - IDLE: tx_stb -> BLANK; clear first_ts, last_ts, hit.
  - BLANK: blank_cnt loads BLANK-1 on entry and decrements. While tx_en=1 it is held at BLANK-1. At 0 -> LISTEN with armed=0 and run counters cleared.
  - LISTEN:
    - run_hi counts consecutive sig_s=1 samples, saturating at RUN_MIN. Any 0 clears it.
    - run_lo counts consecutive sig_s=0 samples, saturating at GAP_MIN. Any 1 clears it.
    - armed sets when run_lo reaches GAP_MIN.
    - When armed and run_hi reaches RUN_MIN: rf_rx_stb=1 for one cycle, armed clears, last_ts=ts_cnt. If hit=0, also first_ts=ts_cnt and hit sets.
    - Latency: sig rising (held high, gap already met) -> rf_rx_stb exactly RUN_MIN+2 cycles later.
  - ts_cnt==WINDOW-1 in BLANK or LISTEN -> win_done=1 that cycle; next state IDLE.
- Boundaries:
  - sig already high on entering LISTEN: no echo until a GAP_MIN low gap followed by RUN_MIN highs.
  - Echo qualifies in the same cycle as the window end: rf_rx_stb and win_done both assert; the timestamp is captured.
  - tx_stb in any non-IDLE state: restart to BLANK and clear hit and timestamps. No win_done for the aborted window.
  - tx_en rising during LISTEN: return to BLANK with blank_cnt held. The window timer continues.
  - first_ts and last_ts hold after IDLE until the next tx_stb.
  - Reset mid-window: immediate IDLE. No win_done.

Optional Feature:
- ECHO_DETECT_CNT_EN defined: adds output hit_cnt[7:0], the number of echoes in the current window. It saturates at 255 and clears on tx_stb.
- Undefined: the port and its counter are absent. All other behaviour is identical.

Decomposition:
- echo_detect_pkg holds:
  - state enum: IDLE, BLANK, LISTEN;
  - default localparams for RUN_MIN, GAP_MIN, BLANK, WINDOW;
  - width helper for run counters.
- One sub-module, echo_run_qual: synchronizer plus run_hi/run_lo/armed logic.
  - Inputs: clk, rst, sig, enable, clear.
  - Output: one-cycle qual_stb.

Test Plan:
- Reset then idle; sig toggling with no tx_stb -> rf_rx_stb, hit, busy stay 0 for 1000 cycles.
- tx_stb at t0; sig low until ts 100, then high for 10 cycles -> rf_rx_stb at ts 106, first_ts=last_ts=106, hit=1, win_done at ts 4095, busy falls next cycle.
- sig high pulses of 3 cycles at ts 200, 300 -> no strobe. Then a 6-cycle pulse at ts 400 -> rf_rx_stb at ts 406 only.
- sig high through BLANK and into LISTEN until ts 150, then low 4 cycles, then high -> single strobe at ts 160. Nothing earlier.
- Two echoes at ts 500 and ts 900, each with a gap ≥4 -> first_ts=506, last_ts=906. With ECHO_DETECT_CNT_EN, hit_cnt=2.
- Second tx_stb at ts 1000 mid-LISTEN -> hit=0, timestamps 0, no win_done for the first window. The new window's win_done comes 4095 cycles later. Also: rst at ts 50 -> IDLE, all outputs 0 next cycle.

Source files
------------

// File: rtl/echo_detect_pkg.sv
// echo_detect_pkg
//   Shared types and defaults for the echo detector front end.
//   - state_t      : top-level FSM states (idle, blanking, listening)
//   - *_DEF        : default values for the detector parameters
//   - run_w()      : bit width needed to hold a run counter saturating at n
package echo_detect_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BLANK  = 2'd1,
    ST_LISTEN = 2'd2
  } state_t;

  localparam int RUN_MIN_DEF = 4;
  localparam int GAP_MIN_DEF = 4;
  localparam int BLANK_DEF   = 64;
  localparam int WINDOW_DEF  = 4096;

  // Width of a counter that must be able to hold the value n (n >= 1).
  function automatic int run_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/echo_run_qual.sv
// echo_run_qual
//   Synchronizes the raw comparator bit and qualifies echo pulses by run
//   length. An echo is accepted only after a low gap of GAP_MIN samples has
//   armed the detector, followed by RUN_MIN consecutive high samples.
// Ports:
//   clk      in  system clock
//   rst      in  synchronous active-high reset
//   sig      in  raw digitizer bit, asynchronous to clk
//   enable   in  counting allowed (detector is listening); low clears runs
//   clear    in  one-cycle clear of run counters and armed flag
//   qual_stb out one-cycle pulse per qualified echo
module echo_run_qual
  import echo_detect_pkg::*;
#(
  parameter int RUN_MIN = RUN_MIN_DEF,
  parameter int GAP_MIN = GAP_MIN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  input  logic enable,
  input  logic clear,
  output logic qual_stb
);

  localparam int RW = run_w(RUN_MIN);
  localparam int GW = run_w(GAP_MIN);
  localparam logic [RW-1:0] RUN_SAT = RW'(RUN_MIN);
  localparam logic [GW-1:0] GAP_SAT = GW'(GAP_MIN);

  logic [1:0]    sync_reg;
  logic          sig_s;
  logic [RW-1:0] run_hi_reg;
  logic [GW-1:0] run_lo_reg;
  logic          armed_reg;

  // Second flop of the synchronizer is the only view of sig used below.
  assign sig_s = sync_reg[1];

  // run_hi is saturated at RUN_MIN, so the strobe fires exactly once per
  // pulse: armed clears on the strobe and only a fresh gap can re-arm it.
  assign qual_stb = enable && !clear && armed_reg && (run_hi_reg == RUN_SAT);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg   <= 2'b00;
      run_hi_reg <= '0;
      run_lo_reg <= '0;
      armed_reg  <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], sig};
      if (clear || !enable) begin
        run_hi_reg <= '0;
        run_lo_reg <= '0;
        armed_reg  <= 1'b0;
      end else begin
        if (sig_s) begin
          run_lo_reg <= '0;
          if (run_hi_reg != RUN_SAT) begin
            run_hi_reg <= run_hi_reg + 1'b1;
          end
        end else begin
          run_hi_reg <= '0;
          if (run_lo_reg != GAP_SAT) begin
            run_lo_reg <= run_lo_reg + 1'b1;
          end
        end
        if (qual_stb) begin
          armed_reg <= 1'b0;
        end else if (run_lo_reg == GAP_SAT) begin
          armed_reg <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/echo_detect.sv
// echo_detect
//   Receiver front end of the ping timing accumulator. After each ping start
//   the receiver is blanked, then listens for qualified echo pulses until the
//   listen window expires. Each echo produces a one-cycle rf_rx_stb and its
//   timestamp (cycles since ping start) is recorded.
// Build option:
//   ECHO_DETECT_CNT_EN  adds the hit_cnt[7:0] output (echoes in window,
//                       saturating at 255, cleared by tx_stb).
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   sig        in   raw digitizer bit, asynchronous to clk
//   tx_stb     in   one-cycle ping start; restarts the window from any state
//   tx_en      in   transmitter active; forces blanking while high
//   rf_rx_stb  out  one-cycle pulse per qualified echo
//   first_ts   out  timestamp of first echo in current window
//   last_ts    out  timestamp of most recent echo in current window
//   hit        out  at least one echo seen in current window
//   win_done   out  one-cycle pulse at end of listen window
//   busy       out  high while blanking or listening
//   hit_cnt    out  echo count (only with ECHO_DETECT_CNT_EN)
module echo_detect
  import echo_detect_pkg::*;
#(
  parameter int RUN_MIN = RUN_MIN_DEF,
  parameter int GAP_MIN = GAP_MIN_DEF,
  parameter int BLANK   = BLANK_DEF,
  parameter int WINDOW  = WINDOW_DEF,
  parameter int TW      = $clog2(WINDOW)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sig,
  input  logic          tx_stb,
  input  logic          tx_en,
  output logic          rf_rx_stb,
  output logic [TW-1:0] first_ts,
  output logic [TW-1:0] last_ts,
  output logic          hit,
  output logic          win_done,
  output logic          busy
`ifdef ECHO_DETECT_CNT_EN
  ,
  output logic [7:0]    hit_cnt
`endif
);

  localparam int BW = (BLANK > 1) ? $clog2(BLANK) : 1;
  localparam logic [BW-1:0] BLANK_LOAD = BW'(BLANK - 1);
  localparam logic [TW-1:0] TS_LAST    = TW'(WINDOW - 1);

  state_t        state_reg, state_next;
  logic [TW-1:0] ts_cnt_reg;
  logic [BW-1:0] blank_cnt_reg;
  logic [TW-1:0] first_ts_reg;
  logic [TW-1:0] last_ts_reg;
  logic          hit_reg;
  logic          qual_stb;
  logic          listening;
  logic          win_end;

  assign listening = (state_reg == ST_LISTEN);
  assign busy      = (state_reg != ST_IDLE);
  assign win_end   = busy && (ts_cnt_reg == TS_LAST);

  // A ping start in the same cycle aborts the current window, so neither
  // its end nor a coincident echo is reported.
  assign win_done  = win_end && !tx_stb;
  assign rf_rx_stb = qual_stb && !tx_stb;

  assign first_ts = first_ts_reg;
  assign last_ts  = last_ts_reg;
  assign hit      = hit_reg;

  echo_run_qual #(
    .RUN_MIN (RUN_MIN),
    .GAP_MIN (GAP_MIN)
  ) u_run_qual (
    .clk      (clk),
    .rst      (rst),
    .sig      (sig),
    .enable   (listening),
    .clear    (tx_stb),
    .qual_stb (qual_stb)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        state_next = ST_IDLE;
      end
      ST_BLANK: begin
        if ((blank_cnt_reg == '0) && !tx_en) begin
          state_next = ST_LISTEN;
        end
      end
      ST_LISTEN: begin
        if (tx_en) begin
          state_next = ST_BLANK;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    if (win_end) begin
      state_next = ST_IDLE;
    end
    if (tx_stb) begin
      state_next = ST_BLANK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      ts_cnt_reg    <= '0;
      blank_cnt_reg <= '0;
      first_ts_reg  <= '0;
      last_ts_reg   <= '0;
      hit_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;

      // The timestamp stops at the last window cycle instead of wrapping.
      if (tx_stb) begin
        ts_cnt_reg <= '0;
      end else if (busy && !win_end) begin
        ts_cnt_reg <= ts_cnt_reg + 1'b1;
      end

      // Blanking restarts from full length on ping start and is held at
      // full length for as long as the transmitter is active.
      if (tx_stb || tx_en) begin
        blank_cnt_reg <= BLANK_LOAD;
      end else if ((state_reg == ST_BLANK) && (blank_cnt_reg != '0)) begin
        blank_cnt_reg <= blank_cnt_reg - 1'b1;
      end

      if (tx_stb) begin
        first_ts_reg <= '0;
        last_ts_reg  <= '0;
        hit_reg      <= 1'b0;
      end else if (rf_rx_stb) begin
        last_ts_reg <= ts_cnt_reg;
        if (!hit_reg) begin
          first_ts_reg <= ts_cnt_reg;
          hit_reg      <= 1'b1;
        end
      end
    end
  end

`ifdef ECHO_DETECT_CNT_EN
  logic [7:0] hit_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_reg <= 8'd0;
    end else if (tx_stb) begin
      hit_cnt_reg <= 8'd0;
    end else if (rf_rx_stb && (hit_cnt_reg != 8'hFF)) begin
      hit_cnt_reg <= hit_cnt_reg + 8'd1;
    end
  end

  assign hit_cnt = hit_cnt_reg;
`endif

endmodule

// File: tb/tb_echo_detect.sv
// tb_echo_detect
//   Scenario bench for echo_detect with default parameters. Expected echo
//   timestamps are queued when a scenario is set up; the strobe monitor pops
//   and compares them against the bench's own count of cycles since ping.
module tb_echo_detect;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sig = 1'b0;
  logic        tx_stb = 1'b0;
  logic        tx_en = 1'b0;
  logic        rf_rx_stb;
  logic [11:0] first_ts;
  logic [11:0] last_ts;
  logic        hit;
  logic        win_done;
  logic        busy;
`ifdef ECHO_DETECT_CNT_EN
  logic [7:0]  hit_cnt;
`endif

  int total = 0;
  int bad = 0;
  int tb_ts = 0;
  int exp_q[$];
  int wd_cnt = 0;
  int wd_ts = -1;
  int wd0 = 0;
  bit use_pat = 1'b0;
  int pre_hi_end = 0;
  int hi_s[$];
  int hi_l[$];

  always #5 clk = ~clk;

  echo_detect dut (
    .clk       (clk),
    .rst       (rst),
    .sig       (sig),
    .tx_stb    (tx_stb),
    .tx_en     (tx_en),
    .rf_rx_stb (rf_rx_stb),
    .first_ts  (first_ts),
    .last_ts   (last_ts),
    .hit       (hit),
    .win_done  (win_done),
    .busy      (busy)
`ifdef ECHO_DETECT_CNT_EN
    ,
    .hit_cnt   (hit_cnt)
`endif
  );

  // Bench-side cycle count since the cycle that sampled tx_stb.
  always @(posedge clk) begin
    if (tx_stb) tb_ts <= 0;
    else        tb_ts <= tb_ts + 1;
  end

  // Scoreboard consumer: every strobe must match the next expected timestamp.
  always @(negedge clk) begin
    if (rf_rx_stb) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL strobe_unexpected got_ts=%0d want=none", tb_ts);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (tb_ts !== e) begin
          bad++;
          $display("FAIL strobe_ts got=%0d want=%0d", tb_ts, e);
        end else begin
          $display("strobe ts=%0d ok", tb_ts);
        end
      end
    end
    if (win_done) begin
      wd_cnt++;
      wd_ts = tb_ts;
      $display("win_done ts=%0d", tb_ts);
    end
  end

  function automatic logic pat(input int t);
    if (t < pre_hi_end) return 1'b1;
    foreach (hi_s[i]) begin
      if ((t >= hi_s[i]) && (t < hi_s[i] + hi_l[i])) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (use_pat) sig = pat(tb_ts);
  endtask

  task automatic ping();
    tx_stb = 1'b1;
    tick();
    tx_stb = 1'b0;
  endtask

  task automatic set_pattern(input int pre);
    use_pat = 1'b1;
    pre_hi_end = pre;
    hi_s.delete();
    hi_l.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    total++;
    if ({rf_rx_stb, hit, win_done, busy} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags got=%b want=0000", {rf_rx_stb, hit, win_done, busy});
    end
    total++;
    if ({first_ts, last_ts} !== 24'd0) begin
      bad++;
      $display("FAIL reset_ts got=%0d/%0d want=0/0", first_ts, last_ts);
    end
    rst = 1'b0;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_idle();
    use_pat = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      tick();
      sig = 1'($urandom_range(0, 1));
      total++;
      if ({rf_rx_stb, hit, busy} !== 3'b000) begin
        bad++;
        $display("FAIL idle_quiet cyc=%0d got=%b want=000", c, {rf_rx_stb, hit, busy});
      end
    end
    sig = 1'b0;
    $display("test_idle done");
  endtask

  task automatic test_single_echo();
    set_pattern(0);
    hi_s.push_back(100); hi_l.push_back(10);
    exp_q.push_back(106);
    wd0 = wd_cnt;
    ping();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL single_busy_start got=%b want=1", busy);
    end
    for (int c = 1; c <= 4095; c++) begin
      tick();
      if (tb_ts == 105) begin
        total++;
        if (hit !== 1'b0) begin
          bad++;
          $display("FAIL single_hit_early got=%b want=0", hit);
        end
      end
      if (tb_ts == 107) begin
        total++;
        if ({hit, first_ts, last_ts} !== {1'b1, 12'd106, 12'd106}) begin
          bad++;
          $display("FAIL single_capture got=%b/%0d/%0d want=1/106/106", hit, first_ts, last_ts);
        end
      end
    end
    total++;
    if ({win_done, busy} !== 2'b11) begin
      bad++;
      $display("FAIL single_win_end got=%b want=11", {win_done, busy});
    end
    tick();
    total++;
    if ({win_done, busy, hit} !== 3'b001) begin
      bad++;
      $display("FAIL single_after got=%b want=001", {win_done, busy, hit});
    end
    total++;
    if ((wd_cnt !== wd0 + 1) || (wd_ts !== 4095)) begin
      bad++;
      $display("FAIL single_wd got=%0d@%0d want=%0d@4095", wd_cnt, wd_ts, wd0 + 1);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL single_missing got=%0d left want=0", exp_q.size());
      exp_q.delete();
    end
    $display("test_single_echo done");
  endtask

  task automatic test_short_pulses();
    set_pattern(0);
    hi_s.push_back(200); hi_l.push_back(3);
    hi_s.push_back(300); hi_l.push_back(3);
    hi_s.push_back(400); hi_l.push_back(6);
    exp_q.push_back(406);
    ping();
    for (int c = 1; c <= 420; c++) tick();
    total++;
    if ({first_ts, last_ts} !== {12'd406, 12'd406}) begin
      bad++;
      $display("FAIL short_ts got=%0d/%0d want=406/406", first_ts, last_ts);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL short_missing got=%0d left want=0", exp_q.size());
      exp_q.delete();
    end
    $display("test_short_pulses done");
  endtask

  task automatic test_high_through_blank();
    set_pattern(150);
    hi_s.push_back(154); hi_l.push_back(100);
    exp_q.push_back(160);
    ping();
    for (int c = 1; c <= 300; c++) tick();
    total++;
    if ({hit, first_ts, last_ts} !== {1'b1, 12'd160, 12'd160}) begin
      bad++;
      $display("FAIL blank_high got=%b/%0d/%0d want=1/160/160", hit, first_ts, last_ts);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL blank_high_missing got=%0d left want=0", exp_q.size());
      exp_q.delete();
    end
    $display("test_high_through_blank done");
  endtask

  task automatic test_back_to_back();
    set_pattern(0);
    hi_s.push_back(500); hi_l.push_back(10);
    hi_s.push_back(900); hi_l.push_back(10);
    exp_q.push_back(506);
    exp_q.push_back(906);
    ping();
    for (int c = 1; c <= 1000; c++) tick();
    total++;
    if ({hit, first_ts, last_ts} !== {1'b1, 12'd506, 12'd906}) begin
      bad++;
      $display("FAIL two_echo got=%b/%0d/%0d want=1/506/906", hit, first_ts, last_ts);
    end
`ifdef ECHO_DETECT_CNT_EN
    total++;
    if (hit_cnt !== 8'd2) begin
      bad++;
      $display("FAIL two_echo_cnt got=%0d want=2", hit_cnt);
    end
`endif
    wd0 = wd_cnt;
    set_pattern(0);
    ping();
    total++;
    if ({hit, first_ts, last_ts, busy} !== {1'b0, 12'd0, 12'd0, 1'b1}) begin
      bad++;
      $display("FAIL restart_clear got=%b/%0d/%0d/%b want=0/0/0/1", hit, first_ts, last_ts, busy);
    end
`ifdef ECHO_DETECT_CNT_EN
    total++;
    if (hit_cnt !== 8'd0) begin
      bad++;
      $display("FAIL restart_cnt got=%0d want=0", hit_cnt);
    end
`endif
    for (int c = 1; c <= 4095; c++) tick();
    total++;
    if ((win_done !== 1'b1) || (wd_cnt !== wd0)) begin
      bad++;
      $display("FAIL restart_win got=%b cnt=%0d want=1 cnt=%0d", win_done, wd_cnt, wd0);
    end
    tick();
    total++;
    if ((wd_cnt !== wd0 + 1) || (busy !== 1'b0)) begin
      bad++;
      $display("FAIL restart_done got=%0d busy=%b want=%0d busy=0", wd_cnt, busy, wd0 + 1);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL two_echo_missing got=%0d left want=0", exp_q.size());
      exp_q.delete();
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_tx_en();
    set_pattern(0);
    hi_s.push_back(230); hi_l.push_back(10);
    hi_s.push_back(300); hi_l.push_back(10);
    exp_q.push_back(306);
    ping();
    for (int c = 1; c <= 320; c++) begin
      tick();
      if (tb_ts == 200) tx_en = 1'b1;
      if (tb_ts == 210) tx_en = 1'b0;
      if (tb_ts == 290) begin
        total++;
        if ({busy, hit} !== 2'b10) begin
          bad++;
          $display("FAIL txen_blanked got=%b want=10", {busy, hit});
        end
      end
    end
    total++;
    if ({hit, first_ts} !== {1'b1, 12'd306}) begin
      bad++;
      $display("FAIL txen_echo got=%b/%0d want=1/306", hit, first_ts);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL txen_missing got=%0d left want=0", exp_q.size());
      exp_q.delete();
    end
    $display("test_tx_en done");
  endtask

  task automatic test_reset_mid();
    set_pattern(0);
    ping();
    for (int c = 1; c <= 50; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({rf_rx_stb, hit, win_done, busy, first_ts, last_ts} !== 28'd0) begin
      bad++;
      $display("FAIL reset_mid got=%b/%0d/%0d want=0000/0/0",
               {rf_rx_stb, hit, win_done, busy}, first_ts, last_ts);
    end
    wd0 = wd_cnt;
    repeat (4200) tick();
    total++;
    if ((wd_cnt !== wd0) || (busy !== 1'b0)) begin
      bad++;
      $display("FAIL reset_mid_nodone got=%0d busy=%b want=%0d busy=0", wd_cnt, busy, wd0);
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_window_edge();
    set_pattern(0);
    hi_s.push_back(4089); hi_l.push_back(20);
    exp_q.push_back(4095);
    ping();
    for (int c = 1; c <= 4095; c++) tick();
    total++;
    if ({rf_rx_stb, win_done} !== 2'b11) begin
      bad++;
      $display("FAIL edge_both got=%b want=11", {rf_rx_stb, win_done});
    end
    tick();
    total++;
    if ({hit, busy, first_ts, last_ts} !== {1'b1, 1'b0, 12'd4095, 12'd4095}) begin
      bad++;
      $display("FAIL edge_capture got=%b/%b/%0d/%0d want=1/0/4095/4095", hit, busy, first_ts, last_ts);
    end
    repeat (10) tick();
    total++;
    if ({hit, first_ts, last_ts} !== {1'b1, 12'd4095, 12'd4095}) begin
      bad++;
      $display("FAIL edge_hold got=%b/%0d/%0d want=1/4095/4095", hit, first_ts, last_ts);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL edge_missing got=%0d left want=0", exp_q.size());
      exp_q.delete();
    end
    $display("test_window_edge done");
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single_echo();
    test_short_pulses();
    test_high_through_blank();
    test_back_to_back();
    test_tx_en();
    test_reset_mid();
    test_window_edge();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
